// File: rtl/fir_mac_sequencer.sv
// Time-multiplexed FIR controller: one shared unsigned MAC walks all taps, one tap per clock,
// with a programmable coefficient bank and a sample delay line behind a valid/ready input.
module fir_mac_sequencer #(
    parameter int TAPS = 4,
    parameter int DW   = 8,
    parameter int CW   = 8,
    parameter int OW   = 16,
    parameter int AW   = $clog2(TAPS)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cfg_we,
    input  logic [AW-1:0] cfg_addr,
    input  logic [CW-1:0] cfg_data,
    output logic          cfg_err,
    input  logic          x_valid,
    input  logic [DW-1:0] x_in,
    output logic          x_ready,
    output logic          y_valid,
    output logic [OW-1:0] y_out,
    output logic          busy
);

    // Wide enough that summing TAPS full-scale products never wraps.
    localparam int ACCW = DW + CW + $clog2(TAPS);
    localparam int SW   = (ACCW > OW) ? ACCW : OW;

    typedef enum logic {
        IDLE,
        MAC
    } state_t;

    state_t state, state_next;

    logic [DW-1:0]   tap  [TAPS];
    logic [CW-1:0]   coef [TAPS];
    logic [ACCW-1:0] acc;
    logic [AW-1:0]   k;

    logic            accept;
    logic            last_tap;
    logic [ACCW-1:0] mac_sum;
    logic [SW-1:0]   sum_ext;
    logic [OW-1:0]   y_sat;

    assign accept   = (state == IDLE) && x_valid;
    assign last_tap = (k == AW'(TAPS - 1));
    assign mac_sum  = acc + ACCW'(coef[k]) * ACCW'(tap[k]);
    assign sum_ext  = SW'(mac_sum);
    assign y_sat    = (sum_ext > SW'({OW{1'b1}})) ? {OW{1'b1}} : sum_ext[OW-1:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every output and next-state term gets a default before the case, so no path
    // leaves a variable unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        x_ready    = 1'b0;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                x_ready = 1'b1;
                if (x_valid) begin
                    state_next = MAC;
                end
            end
            MAC: begin
                busy = 1'b1;
                if (last_tap) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: the coefficient bank and delay line are small flop arrays, not RAM, so they take
    // the asynchronous reset like any other state; all state here updates with <= only.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < TAPS; i++) begin
                tap[i]  <= '0;
                coef[i] <= '0;
            end
            acc     <= '0;
            k       <= '0;
            y_out   <= '0;
            y_valid <= 1'b0;
            cfg_err <= 1'b0;
        end else begin
            y_valid <= 1'b0;
            cfg_err <= 1'b0;

            if (accept) begin
                for (int i = TAPS - 1; i > 0; i--) begin
                    tap[i] <= tap[i-1];
                end
                tap[0] <= x_in;
                acc    <= '0;
                k      <= '0;
            end

            if (state == MAC) begin
                acc <= mac_sum;
                k   <= k + 1'b1;
                if (last_tap) begin
                    y_out   <= y_sat;
                    y_valid <= 1'b1;
                end
            end

            // A write landing on the accept edge commits in time for tap 0 of that sequence.
            if (cfg_we) begin
                if (state == IDLE) begin
                    if (int'(cfg_addr) < TAPS) begin
                        coef[cfg_addr] <= cfg_data;
                    end
                end else begin
                    cfg_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Scoreboard bench for fir_mac_sequencer: the driver queues hand-computed results per accepted
// sample, and a monitor pops and compares value and arrival cycle on every y_valid pulse.
module tb_fir_mac_sequencer;

    localparam int TAPS = 4;
    localparam int DW   = 8;
    localparam int CW   = 8;
    localparam int OW   = 16;
    localparam int AW   = $clog2(TAPS);

    logic          clk;
    logic          reset;
    logic          cfg_we;
    logic [AW-1:0] cfg_addr;
    logic [CW-1:0] cfg_data;
    logic          cfg_err;
    logic          x_valid;
    logic [DW-1:0] x_in;
    logic          x_ready;
    logic          y_valid;
    logic [OW-1:0] y_out;
    logic          busy;

    fir_mac_sequencer #(
        .TAPS(TAPS), .DW(DW), .CW(CW), .OW(OW), .AW(AW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .cfg_we   (cfg_we),
        .cfg_addr (cfg_addr),
        .cfg_data (cfg_data),
        .cfg_err  (cfg_err),
        .x_valid  (x_valid),
        .x_in     (x_in),
        .x_ready  (x_ready),
        .y_valid  (y_valid),
        .y_out    (y_out),
        .busy     (busy)
    );

    typedef struct {
        int value;
        int due;
    } exp_t;

    exp_t q[$];
    int   n_tests;
    int   n_fail;
    int   cyc;
    int   err_seen;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic write_coef(input int addr, input int data);
        @(negedge clk);
        cfg_we   = 1'b1;
        cfg_addr = AW'(addr);
        cfg_data = CW'(data);
        @(posedge clk);
        #1 cfg_we = 1'b0;
    endtask

    // Offers a sample until accepted; queues the expected result if one should follow.
    task automatic send(input int x, input bit want, input int exp_val);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            x_valid = 1'b1;
            x_in    = DW'(x);
            if (x_ready) got = 1'b1;
        end
        if (!got) begin
            fail_now("accept_timeout");
        end else if (want) begin
            q.push_back('{value: exp_val, due: cyc + 1 + TAPS});
        end
        @(posedge clk);
        #1 x_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && q.size() != 0; i++) @(negedge clk);
        if (q.size() != 0) fail_now("drain_timeout");
        repeat (2) @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_y_out"},   int'(y_out),   0);
        check({tag, "_y_valid"}, int'(y_valid), 0);
        check({tag, "_cfg_err"}, int'(cfg_err), 0);
        check({tag, "_busy"},    int'(busy),    0);
        check({tag, "_x_ready"}, int'(x_ready), 1);
    endtask

    int t1_x   [5] = '{10, 20, 30, 0, 5};
    int t1_y   [5] = '{10, 40, 100, 160, 175};
    int t2_y   [4] = '{65025, 65535, 65535, 65535};
    int t3_y   [4] = '{1, 8, 26, 60};
    int t4_err;

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        cyc      = 0;
        err_seen = 0;
        reset    = 1'b0;
        cfg_we   = 1'b0;
        cfg_addr = '0;
        cfg_data = '0;
        x_valid  = 1'b0;
        x_in     = '0;

        fork
            forever begin
                @(negedge clk);
                if (reset && cfg_err) err_seen++;
                if (reset && y_valid) begin
                    if (q.size() == 0) begin
                        fail_now("unexpected_y_valid");
                    end else begin
                        exp_t e;
                        e = q.pop_front();
                        check("y_out", int'(y_out), e.value);
                        check("y_valid_cycle", cyc, e.due);
                    end
                end
            end
        join_none

        repeat (2) @(negedge clk);
        check_reset_outputs("por");
        reset = 1'b1;

        // Impulse-like sequence with coefficients 1..4.
        for (int i = 0; i < TAPS; i++) write_coef(i, i + 1);
        for (int i = 0; i < 5; i++) send(t1_x[i], 1'b1, t1_y[i]);
        drain();

        // Saturation with full-scale coefficients and samples.
        do_reset();
        for (int i = 0; i < TAPS; i++) write_coef(i, 255);
        for (int i = 0; i < 4; i++) send(255, 1'b1, t2_y[i]);
        drain();

        // Back-pressure: x_valid held high, sample value changes every cycle.
        do_reset();
        for (int i = 0; i < TAPS; i++) write_coef(i, i + 1);
        begin
            logic [19:0] ready_pat;
            int          n_acc;
            ready_pat = '0;
            n_acc     = 0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                x_valid      = 1'b1;
                x_in         = DW'(i + 1);
                ready_pat[i] = x_ready;
                if (x_ready) begin
                    if (n_acc < 4) q.push_back('{value: t3_y[n_acc], due: cyc + 1 + TAPS});
                    n_acc++;
                end
            end
            @(negedge clk);
            x_valid = 1'b0;
            check("ready_pattern", int'(ready_pat), int'(20'h08421));
        end
        drain();

        // Write during MAC is dropped and flagged.
        do_reset();
        for (int i = 0; i < TAPS; i++) write_coef(i, i + 1);
        t4_err = err_seen;
        send(10, 1'b1, 10);
        @(negedge clk);
        check("busy_in_mac", int'(busy), 1);
        cfg_we   = 1'b1;
        cfg_addr = AW'(1);
        cfg_data = CW'(9);
        @(posedge clk);
        #1 cfg_we = 1'b0;
        drain();
        check("cfg_err_pulses", err_seen - t4_err, 1);
        send(20, 1'b1, 40);
        drain();

        // Simultaneous write and accept on the same edge.
        do_reset();
        @(negedge clk);
        check("t5_ready", int'(x_ready), 1);
        cfg_we   = 1'b1;
        cfg_addr = AW'(0);
        cfg_data = CW'(7);
        x_valid  = 1'b1;
        x_in     = DW'(3);
        q.push_back('{value: 21, due: cyc + 1 + TAPS});
        @(posedge clk);
        #1;
        cfg_we  = 1'b0;
        x_valid = 1'b0;
        drain();

        // Reset mid-MAC aborts; coefficients come back zeroed.
        do_reset();
        for (int i = 0; i < TAPS; i++) write_coef(i, i + 1);
        send(10, 1'b0, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        check_reset_outputs("mid_mac");
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (10) @(negedge clk);
        send(50, 1'b1, 0);
        drain();

        check("cfg_err_total", err_seen, 1);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
